// File: rtl/pe_multicaster.sv
// rtl/pe_multicaster.sv - column MultiCaster: tag filter, beat FIFO, PE handshake
//
// Takes tagged {ifmap, fltr, psum} beats from the row bus. A beat whose tag
// equals col_id is buffered and later delivered to the PE. A beat with any
// other tag is consumed and discarded, so it never stalls the bus.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   caster_en, kernel_size  start pulse; kernel_size is latched when it fires
//   flush                   abort and empty the buffer
//   col_id, bus_tag         this column's ID; destination tag of the bus beat
//   bus_valid/bus_ready     bus handshake
//   bus_ifmap/fltr/psum     bus beat payload
//   pe_en                   PE enable (high while running)
//   pe_valid/pe_ready       PE handshake on the FIFO head
//   pe_ifmap/fltr/psum      FIFO head payload (zero when pe_valid is low)
//   pe_last                 the head beat closes a kernel window
//   pe_kernel_size          latched kernel_size
//   fifo_count              number of buffered beats
module pe_multicaster #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int TW = $clog2(NUM_COL),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    caster_en,
    input  logic [7:0]              kernel_size,
    input  logic                    flush,
    input  logic [TW-1:0]           col_id,
    input  logic [TW-1:0]           bus_tag,
    input  logic                    bus_valid,
    output logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_ifmap,
    input  logic [DATA_WIDTH-1:0]   bus_fltr,
    input  logic [2*DATA_WIDTH-1:0] bus_psum,
    output logic                    pe_en,
    output logic                    pe_valid,
    input  logic                    pe_ready,
    output logic [DATA_WIDTH-1:0]   pe_ifmap,
    output logic [DATA_WIDTH-1:0]   pe_fltr,
    output logic [2*DATA_WIDTH-1:0] pe_psum,
    output logic                    pe_last,
    output logic [7:0]              pe_kernel_size,
    output logic [CW-1:0]           fifo_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 4 * DATA_WIDTH;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      win_cnt_q;
    logic [7:0]      ks_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic            full;
    logic            tag_match;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    assign full      = (count_q == CNT_FULL);
    assign tag_match = (bus_tag == col_id);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // flush wins over caster_en in every state; a held flush keeps us in FLUSH.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:  if (caster_en) state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                S_FLUSH: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // A full FIFO only back-pressures beats meant for this column; foreign
    // beats are always swallowed so the shared bus keeps moving.
    always_comb begin
        pe_en     = 1'b0;
        bus_ready = 1'b0;
        pe_valid  = 1'b0;
        if (state_q == S_RUN) begin
            pe_en     = 1'b1;
            bus_ready = !full || !tag_match;
            pe_valid  = (count_q != '0);
        end
    end

    assign push = bus_valid && bus_ready && tag_match;
    assign pop  = pe_valid && pe_ready;

    // ---------------- FIFO storage (no reset needed: reads are gated) ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus_ifmap, bus_fltr, bus_psum};
        end
    end

    // ---------------- pointers, count, window counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            win_cnt_q <= '0;
        end else if (state_q == S_FLUSH) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            win_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            // With kernel_size 0 pe_last never fires and the 8-bit counter
            // simply rolls over at 255.
            if (pop) begin
                win_cnt_q <= pe_last ? 8'd0 : win_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_q <= '0;
        end else if (state_q == S_IDLE && caster_en && !flush) begin
            ks_q <= kernel_size;
        end
    end

    // ---------------- PE side ----------------
    assign head     = mem_q[rd_ptr_q];
    assign pe_ifmap = pe_valid ? head[EW-1 -: DATA_WIDTH]              : '0;
    assign pe_fltr  = pe_valid ? head[2*DATA_WIDTH +: DATA_WIDTH]      : '0;
    assign pe_psum  = pe_valid ? head[2*DATA_WIDTH-1:0]                : '0;
    assign pe_last  = pe_valid && (ks_q != 8'd0) && (win_cnt_q == ks_q - 8'd1);

    assign pe_kernel_size = ks_q;
    assign fifo_count     = count_q;

endmodule

// File: tb/tb_pe_multicaster.sv
// tb/tb_pe_multicaster.sv - randomized self-checking bench for pe_multicaster
module tb_pe_multicaster;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int FD = 4;

    logic        clk;
    logic        rst_n;
    logic        caster_en;
    logic [7:0]  kernel_size;
    logic        flush;
    logic [1:0]  col_id;
    logic [1:0]  bus_tag;
    logic        bus_valid;
    logic        bus_ready;
    logic [15:0] bus_ifmap;
    logic [15:0] bus_fltr;
    logic [31:0] bus_psum;
    logic        pe_en;
    logic        pe_valid;
    logic        pe_ready;
    logic [15:0] pe_ifmap;
    logic [15:0] pe_fltr;
    logic [31:0] pe_psum;
    logic        pe_last;
    logic [7:0]  pe_kernel_size;
    logic [2:0]  fifo_count;

    pe_multicaster #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .caster_en      (caster_en),
        .kernel_size    (kernel_size),
        .flush          (flush),
        .col_id         (col_id),
        .bus_tag        (bus_tag),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_ifmap      (bus_ifmap),
        .bus_fltr       (bus_fltr),
        .bus_psum       (bus_psum),
        .pe_en          (pe_en),
        .pe_valid       (pe_valid),
        .pe_ready       (pe_ready),
        .pe_ifmap       (pe_ifmap),
        .pe_fltr        (pe_fltr),
        .pe_psum        (pe_psum),
        .pe_last        (pe_last),
        .pe_kernel_size (pe_kernel_size),
        .fifo_count     (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode 0 idle, 1 running, 2 flushing.
    int          m_mode = 0;
    logic [63:0] m_q[$];
    int          m_win = 0;
    int          m_ks = 0;
    int          n_last = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_win = 0;
        m_ks = 0;
    endtask

    // Called at a negedge with inputs already applied; checks, advances the
    // model, and returns at the next negedge.
    task automatic step();
        bit          running, exp_ready, exp_valid, exp_last, do_push, do_pop;
        logic [63:0] exp_head;
        #1;
        running   = (m_mode == 1);
        exp_valid = running && (m_q.size() > 0);
        exp_ready = running && ((m_q.size() < FD) || (bus_tag != col_id));
        exp_head  = exp_valid ? m_q[0] : 64'd0;
        exp_last  = exp_valid && (m_ks != 0) && (m_win == m_ks - 1);
        chk("bus_ready", bus_ready, exp_ready);
        chk("pe_valid", pe_valid, exp_valid);
        chk("pe_en", pe_en, running);
        chk("pe_data", {pe_ifmap, pe_fltr, pe_psum}, exp_head);
        chk("pe_last", pe_last, exp_last);
        chk("fifo_count", fifo_count, m_q.size());
        chk("pe_kernel_size", pe_kernel_size, m_ks);
        if (pe_last) n_last++;
        do_push = exp_ready && bus_valid && (bus_tag == col_id);
        do_pop  = exp_valid && pe_ready;
        if (do_pop) begin
            void'(m_q.pop_front());
            m_win = exp_last ? 0 : (m_win + 1) % 256;
        end
        if (do_push) m_q.push_back({bus_ifmap, bus_fltr, bus_psum});
        if (m_mode == 2) begin
            m_q.delete();
            m_win = 0;
        end
        if (flush) m_mode = 2;
        else if (m_mode == 0 && caster_en) begin
            m_mode = 1;
            m_ks = kernel_size;
        end else if (m_mode == 2) m_mode = 0;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [1:0] tag, input bit rdy);
        bus_valid = v;
        bus_tag   = tag;
        pe_ready  = rdy;
        bus_ifmap = 16'($urandom);
        bus_fltr  = 16'($urandom);
        bus_psum  = $urandom;
    endtask

    task automatic start(input logic [7:0] ks);
        drive(1'b0, 2'd0, 1'b0);
        caster_en   = 1'b1;
        kernel_size = ks;
        step();
        caster_en = 1'b0;
    endtask

    task automatic pulse_flush();
        drive(1'b0, 2'd0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pe_en", pe_en, 1'b0);
        chk("rst_pe_valid", pe_valid, 1'b0);
        chk("rst_bus_ready", bus_ready, 1'b0);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_pe_last", pe_last, 1'b0);
        chk("rst_pe_data", {pe_ifmap, pe_fltr, pe_psum}, 64'd0);
        chk("rst_kernel_size", pe_kernel_size, 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        caster_en = 1'b0;
        kernel_size = 8'd0;
        flush = 1'b0;
        col_id = 2'd2;
        drive(1'b0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_fifo_count", fifo_count, 3'd0);
        chk("reset_pe_en", pe_en, 1'b0);
        rst_n = 1'b1;
        step();

        // 1: three matching beats, window of 3
        start(8'd3);
        n_last = 0;
        for (int i = 0; i < 3; i++) begin drive(1'b1, 2'd2, 1'b1); step(); end
        drive(1'b0, 2'd2, 1'b1);
        repeat (3) step();
        chk("t1_last_count", n_last, 1);
        chk("t1_drained", fifo_count, 3'd0);

        // 2: foreign beats are swallowed
        for (int i = 0; i < 4; i++) begin drive(1'b1, 2'd1, 1'b1); step(); end

        // 3/4: stall the PE, fill, offer a fifth, then a foreign beat while full
        for (int i = 0; i < 5; i++) begin drive(1'b1, 2'd2, 1'b0); step(); end
        chk("t3_full", fifo_count, 3'd4);
        drive(1'b1, 2'd0, 1'b0);
        step();
        chk("t4_full_kept", fifo_count, 3'd4);
        drive(1'b1, 2'd2, 1'b1);
        step();
        bus_valid = 1'b0;
        repeat (6) step();

        // 5: flush with three buffered beats, then restart with ks=2
        for (int i = 0; i < 3; i++) begin drive(1'b1, 2'd2, 1'b0); step(); end
        pulse_flush();
        step();
        chk("t5_count_cleared", fifo_count, 3'd0);
        start(8'd2);
        n_last = 0;
        for (int i = 0; i < 2; i++) begin drive(1'b1, 2'd2, 1'b1); step(); end
        drive(1'b0, 2'd2, 1'b1);
        repeat (2) step();
        chk("t5_last_count", n_last, 1);

        // 6: asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin drive(1'b1, 2'd2, 1'b0); step(); end
        async_reset_check();
        drive(1'b0, 2'd0, 1'b0);
        repeat (2) step();

        // kernel_size 0: no pe_last across a counter rollover
        start(8'd0);
        n_last = 0;
        for (int i = 0; i < 300; i++) begin drive(1'b1, 2'd2, 1'b1); step(); end
        chk("ks0_no_last", n_last, 0);
        pulse_flush();
        step();

        // randomized traffic
        for (int r = 0; r < 20; r++) begin
            if (r % 5 == 0) begin
                col_id = 2'($urandom);
                async_reset_check();
            end
            case ($urandom_range(0, 4))
                0:       start(8'd1);
                1:       start(8'd0);
                2:       start(8'($urandom_range(2, 6)));
                default: start(8'($urandom));
            endcase
            for (int c = 0; c < 150; c++) begin
                drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 2) != 0);
                caster_en   = ($urandom_range(0, 9) == 0);
                kernel_size = 8'($urandom);
                flush       = ($urandom_range(0, 59) == 0);
                step();
            end
            caster_en = 1'b0;
            flush = 1'b0;
            pulse_flush();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
